// File: rtl/char_text_buffer.sv
// char_text_buffer: 80x60 text-cell store with write cursor, clear sweep and 2-cycle glyph lookup.
// Define TEXTBUF_SCROLL_EN to scroll through a row-base register instead of wrapping to row 0.
module char_text_buffer #(
    parameter int COLS   = 80,
    parameter int ROWS   = 60,
    parameter int CODE_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [CODE_W-1:0] wr_code,
    output logic              busy,
    output logic [6:0]        cursor_col,
    output logic [5:0]        cursor_row,
    input  logic [9:0]        rd_x,
    input  logic [9:0]        rd_y,
    input  logic              rd_en,
    output logic [CODE_W-1:0] glyph_code,
    output logic [2:0]        glyph_row,
    output logic [2:0]        glyph_col,
    output logic              glyph_valid
);
    localparam logic [6:0]        LAST_COL  = 7'(COLS - 1);
    localparam logic [5:0]        LAST_ROW  = 6'(ROWS - 1);
    localparam logic [6:0]        ROWS7     = 7'(ROWS);
    localparam logic [12:0]       LAST_CELL = 13'(COLS * ROWS - 1);
    localparam logic [CODE_W-1:0] CODE_CLR  = CODE_W'('h3E);
    localparam logic [CODE_W-1:0] CODE_NL   = CODE_W'('h3F);

`ifdef TEXTBUF_SCROLL_EN
    typedef enum logic [1:0] {CLEAR, IDLE, ROWCLR} state_t;
    logic [5:0] base_q, base_d, base;
    assign base = base_q;
`else
    typedef enum logic [0:0] {CLEAR, IDLE} state_t;
    logic [5:0] base;
    assign base = '0;
`endif

    state_t             state_q, state_d;
    logic [6:0]         col_q, col_d;
    logic [5:0]         row_q, row_d;
    logic [12:0]        clr_q, clr_d;
    logic               we, adv;
    logic [12:0]        wa;
    logic [CODE_W-1:0]  wd;
    logic [CODE_W-1:0]  mem [COLS*ROWS];
    logic [12:0]        ra_q;
    logic [2:0]         frow_q, fcol_q, grow_q, gcol_q;
    logic               en_q, gvalid_q;
    logic [CODE_W-1:0]  gcode_q;

    function automatic logic [12:0] cell_addr(input logic [5:0] r, input logic [6:0] c);
        return ({7'd0, r} << 6) + ({7'd0, r} << 4) + {6'd0, c};
    endfunction

    function automatic logic [5:0] phys(input logic [6:0] r, input logic [5:0] b);
        logic [6:0] s;
        s = r + {1'b0, b};
        return s >= ROWS7 ? 6'(s - ROWS7) : s[5:0];
    endfunction

    assign busy        = state_q != IDLE;
    assign cursor_col  = col_q;
    assign cursor_row  = row_q;
    assign glyph_code  = gcode_q;
    assign glyph_row   = grow_q;
    assign glyph_col   = gcol_q;
    assign glyph_valid = gvalid_q;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        clr_d   = clr_q;
        we      = 1'b0;
        wd      = '0;
        adv     = 1'b0;
        wa      = cell_addr(phys({1'b0, row_q}, base), col_q);
`ifdef TEXTBUF_SCROLL_EN
        base_d  = base_q;
`endif
        case (state_q)
            CLEAR: begin
                we    = 1'b1;
                wa    = clr_q;
                clr_d = clr_q + 13'd1;
                col_d = '0;
                row_d = '0;
`ifdef TEXTBUF_SCROLL_EN
                base_d = '0;
`endif
                if (clr_q == LAST_CELL) begin
                    state_d = IDLE;
                    clr_d   = '0;
                end
            end
`ifdef TEXTBUF_SCROLL_EN
            // base already points one past the freshly exposed bottom row
            ROWCLR: begin
                we    = 1'b1;
                wa    = cell_addr(base == '0 ? LAST_ROW : base - 6'd1, clr_q[6:0]);
                clr_d = clr_q + 13'd1;
                if (clr_q[6:0] == LAST_COL) begin
                    state_d = IDLE;
                    clr_d   = '0;
                end
            end
`endif
            default: if (wr_en) begin
                if (wr_code == CODE_CLR) begin
                    state_d = CLEAR;
                    col_d   = '0;
                    row_d   = '0;
                end else begin
                    we    = wr_code != CODE_NL;
                    wd    = wr_code;
                    adv   = !we || col_q == LAST_COL;
                    col_d = adv ? '0 : col_q + 7'd1;
                end
            end
        endcase
        if (adv) begin
            if (row_q != LAST_ROW) row_d = row_q + 6'd1;
`ifdef TEXTBUF_SCROLL_EN
            else begin
                base_d  = base_q == LAST_ROW ? '0 : base_q + 6'd1;
                state_d = ROWCLR;
            end
`else
            else row_d = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= CLEAR;
            col_q    <= '0;
            row_q    <= '0;
            clr_q    <= '0;
            ra_q     <= '0;
            frow_q   <= '0;
            fcol_q   <= '0;
            en_q     <= 1'b0;
            gcode_q  <= '0;
            grow_q   <= '0;
            gcol_q   <= '0;
            gvalid_q <= 1'b0;
`ifdef TEXTBUF_SCROLL_EN
            base_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            clr_q    <= clr_d;
            ra_q     <= cell_addr(phys(rd_y[9:3], base), rd_x[9:3]);
            frow_q   <= rd_y[2:0];
            fcol_q   <= rd_x[2:0];
            en_q     <= rd_en;
            gcode_q  <= busy ? '0 : mem[ra_q];
            grow_q   <= frow_q;
            gcol_q   <= fcol_q;
            gvalid_q <= en_q;
`ifdef TEXTBUF_SCROLL_EN
            base_q   <= base_d;
`endif
        end
    end
endmodule

// File: tb/tb_char_text_buffer.sv
// tb_char_text_buffer: scoreboard bench for char_text_buffer; reads are queued with model values and
// checked when glyph_valid returns. Follows TEXTBUF_SCROLL_EN like the design.
module tb_char_text_buffer;
    logic       clk = 1'b0, reset = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
    logic [5:0] wr_code = '0;
    logic [9:0] rd_x = '0, rd_y = '0;
    logic       busy, glyph_valid;
    logic [6:0] cursor_col;
    logic [5:0] cursor_row, glyph_code;
    logic [2:0] glyph_row, glyph_col;

    char_text_buffer dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_code(wr_code), .busy(busy),
        .cursor_col(cursor_col), .cursor_row(cursor_row), .rd_x(rd_x), .rd_y(rd_y),
        .rd_en(rd_en), .glyph_code(glyph_code), .glyph_row(glyph_row),
        .glyph_col(glyph_col), .glyph_valid(glyph_valid)
    );

    always #5 clk = ~clk;

    typedef struct {int code; int r; int c; int t;} exp_t;
    exp_t q[$];
    exp_t me;
    int   tests = 0, fails = 0, cyc = 0;
    int   scr[60][80];
    int   mcol = 0, mrow = 0, mbusy = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string tag, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic mclear();
        for (int r = 0; r < 60; r++)
            for (int c = 0; c < 80; c++) scr[r][c] = 0;
    endtask

    task automatic mput(int code);
        mbusy = 0;
        if (code == 62) begin
            mclear();
            mcol  = 0;
            mrow  = 0;
            mbusy = 4800;
        end else begin
            if (code != 63) scr[mrow][mcol] = code;
            if (code == 63 || mcol == 79) begin
                mcol = 0;
                if (mrow < 59) mrow++;
                else begin
`ifdef TEXTBUF_SCROLL_EN
                    for (int r = 0; r < 59; r++)
                        for (int c = 0; c < 80; c++) scr[r][c] = scr[r+1][c];
                    for (int c = 0; c < 80; c++) scr[59][c] = 0;
                    mbusy = 80;
`else
                    mrow = 0;
`endif
                end
            end else mcol++;
        end
    endtask

    task automatic wr(int code);
        wr_code = 6'(code);
        wr_en   = 1'b1;
        mput(code);
        @(negedge clk);
        wr_en = 1'b0;
        chk("cursor_col", int'(cursor_col), mcol);
        chk("cursor_row", int'(cursor_row), mrow);
    endtask

    task automatic wait_idle(string tag, int exp, int drop_at);
        int n = 0;
        while (busy && n < 10000) begin
            wr_en   = n == drop_at;
            wr_code = 6'd4;
            n++;
            @(negedge clk);
        end
        wr_en = 1'b0;
        chk(tag, n, exp);
    endtask

    task automatic rd(int x, int y);
        exp_t e;
        e.code = scr[y/8][x/8];
        e.r    = y % 8;
        e.c    = x % 8;
        e.t    = cyc;
        q.push_back(e);
        rd_x  = 10'(x);
        rd_y  = 10'(y);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    always @(negedge clk) begin
        if (glyph_valid) begin
            if (q.size() == 0) chk("spurious_valid", 1, 0);
            else begin
                me = q.pop_front();
                chk("glyph_code", int'(glyph_code), me.code);
                chk("glyph_row", int'(glyph_row), me.r);
                chk("glyph_col", int'(glyph_col), me.c);
                chk("latency", cyc - me.t, 2);
            end
        end
    end

    initial begin
        mclear();
        repeat (3) @(negedge clk);
        chk("rst_col", int'(cursor_col), 0);
        chk("rst_row", int'(cursor_row), 0);
        chk("rst_gcode", int'(glyph_code), 0);
        chk("rst_grow", int'(glyph_row), 0);
        chk("rst_gcol", int'(glyph_col), 0);
        chk("rst_gvalid", int'(glyph_valid), 0);
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        wait_idle("init_busy", 4800, -1);
        chk("init_col", int'(cursor_col), 0);
        chk("init_row", int'(cursor_row), 0);
        rd(0, 0); rd(639, 479); rd(325, 200); rd(100, 300);

        wr(1); wr(2); wr(3);
        rd(8, 0); rd(21, 5); rd(3, 7);
        for (int i = 0; i < 76; i++) wr(9);
        rd(624, 0); rd(632, 0);

        // clear issued at the last column; a write during the sweep must be lost
        wr(62);
        wait_idle("clear_busy", 4800, 100);
        chk("clr_col", int'(cursor_col), 0);
        chk("clr_row", int'(cursor_row), 0);
        rd(0, 0); rd(16, 0); rd(624, 0);

        for (int i = 0; i < 81; i++) wr(5);
        rd(0, 8); rd(632, 0); rd(8, 8);

        wr(63); wr(63); wr(63);
        for (int i = 0; i < 10; i++) wr(7);
        wr(63);
        rd(80, 32); rd(72, 32); rd(0, 40);

        while (mrow != 59) wr(63);
        wr(17);
        wr(63);
        wait_idle("scroll_busy", mbusy, -1);
        rd(0, 0); rd(0, 464); rd(0, 472); rd(8, 472);
        wr(20);
        rd(0, 472); rd(0, 0);

        rd_x = 10'd13; rd_y = 10'd13;
        repeat (4) @(negedge clk);
        wr(62);
        repeat (2000) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_col", int'(cursor_col), 0);
        chk("mid_row", int'(cursor_row), 0);
        chk("mid_gcode", int'(glyph_code), 0);
        chk("mid_grow", int'(glyph_row), 0);
        chk("mid_gcol", int'(glyph_col), 0);
        chk("mid_gvalid", int'(glyph_valid), 0);
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        wait_idle("restart_busy", 4800, -1);
        rd(0, 0); rd(0, 472); rd(639, 479);
        repeat (4) @(negedge clk);
        chk("drain", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/char_text_buffer.md
# char_text_buffer

Text-mode character buffer between the MIPS `charprint` strobe and the glyph ROM (`charmem`). It stores one 6-bit character code per 8×8 cell of the 640×480 screen, 80×60 cells, and manages a write cursor with wrap, newline and clear-screen. It also translates the VGA pixel position into the cell code plus in-glyph row/column that `charmem` and the pixel serializer consume.

## Interface
Parameters:
- `COLS`, 80, cells per row
- `ROWS`, 60, cell rows
- `CODE_W`, 6, character code width

Ports:
- `clk` in 1: system clock (CLOCK_25 domain).
- `reset` in 1: asynchronous, active-low reset.
- `wr_en` in 1: one-cycle character write strobe (driven by `charprint`).
- `wr_code` in CODE_W: character code (`readdata[25:20]`).
- `busy` out 1: clear sweep in progress; writes ignored.
- `cursor_col` out 7: current cursor column.
- `cursor_row` out 6: current logical cursor row.
- `rd_x` in 10: VGA pixel x, 0..639.
- `rd_y` in 10: VGA pixel y, 0..479.
- `rd_en` in 1: display-active qualifier.
- `glyph_code` out CODE_W: cell code for `charmem`.
- `glyph_row` out 3: `rd_y[2:0]`, aligned with `glyph_code`.
- `glyph_col` out 3: `rd_x[2:0]`, aligned with `glyph_code`.
- `glyph_valid` out 1: `rd_en` delayed to align with `glyph_code`.

## Operation
- Storage: COLS×ROWS words of CODE_W bits, single-clock dual-port: one write port, one read port. Address = row*80 + col, computed as `(row<<6)+(row<<4)+col`, 13 bits.
- FSM states: CLEAR, IDLE, (ROWCLR with scroll only).
  - CLEAR: writes code 0 to addresses 0..COLS*ROWS-1, one per cycle. `busy`=1. On the last address, go to IDLE with cursor (0,0).
  - IDLE: on `wr_en` the block decodes `wr_code`:
    - 6'h3E (clear): enter CLEAR next cycle. Nothing is stored.
    - 6'h3F (newline): col←0, row advances. Nothing is stored.
    - Any other code: stored at the cursor, then col+1. At col=COLS-1 the cursor wraps to col 0 and the row advances.
- Row advance from row<ROWS-1: row+1. From row ROWS-1: see Configuration.
- `wr_en` while `busy`=1 is dropped without effect.
- Read path: cell address comes from `rd_y>>3`, `rd_x>>3`, plus the row base (scroll only).
- Same-cycle read and write of one cell returns the old value (read-before-write).
- While `busy`=1, `glyph_code` is forced to 0.
- Reset: `cursor_col`=0, `cursor_row`=0, `glyph_code`=0, `glyph_row`=0, `glyph_col`=0, `glyph_valid`=0. The FSM enters CLEAR, so `busy`=1 from the first clock after reset deassertion. Reset asserted mid-sweep aborts the sweep, and the sweep restarts from address 0 after release.

## Timing
- Write: code is visible in RAM the cycle after the `wr_en` edge. Cursor outputs update on the same edge.
- Back-to-back `wr_en` every cycle is supported in IDLE.
- Clear: `busy` is high for exactly COLS*ROWS = 4800 cycles. The first `wr_en` is accepted on the cycle `busy` reads 0.
- Read latency: 2 cycles from `rd_x`/`rd_y`/`rd_en` to `glyph_code`/`glyph_row`/`glyph_col`/`glyph_valid`.
  - Stage 1 registers the address and the fine bits.
  - Stage 2 is the RAM output.
  - `glyph_row`, `glyph_col` and `glyph_valid` are delayed 2 cycles to match.
- Clear code (6'h3E) arriving at the wrap position behaves as clear. No store occurs.

## Configuration
- `TEXTBUF_SCROLL_EN` defined:
  - Hardware scroll via a row-base register `base` (0..ROWS-1). Physical row = (logical row + base) mod ROWS, applied to both write and read addresses.
  - A row advance from logical row ROWS-1 keeps the cursor at row ROWS-1 and sets base←(base+1) mod ROWS.
  - It then enters ROWCLR, writing 0 to the COLS cells of the new bottom physical row. `busy`=1 for 80 cycles.
  - CLEAR resets base to 0.
- Not defined:
  - Row advance from ROWS-1 wraps the cursor to row 0 with no clearing and no `busy`.
  - No base register. The ROWCLR state is absent.

## Test plan
- Reset release → `busy`=1 for 4800 cycles, then 0. A read of every cell (sample of x,y) → `glyph_code`=0. Cursor = (0,0).
- Write codes 1,2,3, then read pixel (8,0) → after 2 cycles `glyph_code`=2, `glyph_col`=0, `glyph_valid`=1. Cursor = (3,0).
- 80 writes of 6'h05 followed by one more → cursor (1,1). Pixel (0,8) reads 6'h05.
- At (10,4) write 6'h3F → cursor (0,5), no cell changed. Then 6'h3E → `busy` 4800 cycles. A `wr_en` during the sweep is dropped and the cursor is still (0,0) afterwards.
- Scroll build: fill rows to ROWS-1, then newline → cursor (0,59), `busy` 80 cycles. Pixel (0,0) shows the former row 1 content and row 59 reads 0. Non-scroll build: cursor (0,0).
- Assert `reset` mid-clear at address 2000 → all outputs return to reset values. After release the sweep restarts and `busy` stays high for a full 4800 cycles.
